// File: rtl/lwe_pkg.sv
// Shared LWE definitions for the encrypt/decrypt datapaths: FSM states,
// default ring widths, the rounding constants and the power-of-two modular reduce.
package lwe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } lwe_state_t;

  localparam int DEF_CIPHERTEXT_WIDTH = 10;
  localparam int DEF_PLAINTEXT_WIDTH  = 6;
  localparam int DELTA_SHIFT          = DEF_CIPHERTEXT_WIDTH - DEF_PLAINTEXT_WIDTH;
  localparam int ROUND_OFFSET         = 1 << (DELTA_SHIFT - 1);

  // q is a power of two, so reduction is a mask down to the word width.
  function automatic logic [63:0] mod_reduce(input logic [63:0] x, input int unsigned width);
    return x & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/mod_mac.sv
// Combinational modular multiply-accumulate: sum = (acc + a*s) mod 2^W.
// The product is formed at full 2W width before the sum is reduced.
module mod_mac
  import lwe_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] s,
  output logic [W-1:0] sum
);

  logic [2*W-1:0] product;

  assign product = (2*W)'(a) * (2*W)'(s);
  assign sum     = W'(mod_reduce(64'(acc) + 64'(product), W));

endmodule

// File: rtl/decrypt.sv
// LWE decryption engine: streams a[0..n-1] then b, computes v = b - <a,s> mod q
// and rounds v to a plaintext symbol. Optional noise output: DECRYPT_NOISE_OUT_EN.
module decrypt
  import lwe_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
  parameter int DIMENSION          = 1,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go,
  input  logic [CIPHERTEXT_WIDTH-1:0] secretkey [DIMENSION-1:0],
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_data,
  input  logic                        ct_valid,
  output logic                        ct_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  output logic                        pt_valid,
`ifdef DECRYPT_NOISE_OUT_EN
  output logic signed [CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH:0] noise,
`endif
  input  logic                        pt_ready
);

  localparam int CW     = CIPHERTEXT_WIDTH;
  localparam int PW     = PLAINTEXT_WIDTH;
  localparam int DSHIFT = CW - PW;
  localparam int ROUND  = CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS);
  localparam int IDX_W  = $clog2(DIMENSION + 1);

  lwe_state_t        state_reg, state_next;
  logic [CW-1:0]     acc_reg, acc_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CW-1:0]     v_reg, v_next;
  logic [PW-1:0]     plaintext_reg, plaintext_next;
  logic              pt_valid_reg, pt_valid_next;
  logic [CW-1:0]     key_sel;
  logic [CW-1:0]     mac_sum;
  logic [CW-1:0]     rounded;
  logic [PW-1:0]     pt_decoded;

  mod_mac #(.W(CW)) u_mac (
    .acc (acc_reg),
    .a   (ct_data),
    .s   (key_sel),
    .sum (mac_sum)
  );

  // Rounding offset wraps mod q, so values just below q decode to symbol 0.
  assign rounded    = v_reg + CW'(ROUND);
  assign pt_decoded = PW'(rounded >> DSHIFT);

`ifdef DECRYPT_NOISE_OUT_EN
  logic [CW-1:0]   noise_diff;
  logic [DSHIFT:0] noise_reg, noise_next;

  assign noise_diff = v_reg - {pt_decoded, {DSHIFT{1'b0}}};
  assign noise      = $signed(noise_reg);
`endif

  always_comb begin
    key_sel = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      if (idx_reg == IDX_W'(i)) key_sel = secretkey[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    idx_next       = idx_reg;
    v_next         = v_reg;
    plaintext_next = plaintext_reg;
    pt_valid_next  = pt_valid_reg;
`ifdef DECRYPT_NOISE_OUT_EN
    noise_next     = noise_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = ACCUM;
          acc_next   = '0;
          idx_next   = '0;
        end
      end
      ACCUM: begin
        if (ct_valid) begin
          if (idx_reg == IDX_W'(DIMENSION)) begin
            v_next     = ct_data - acc_reg;
            state_next = DECODE;
          end else begin
            acc_next = mac_sum;
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DECODE: begin
        plaintext_next = pt_decoded;
`ifdef DECRYPT_NOISE_OUT_EN
        noise_next     = noise_diff[DSHIFT:0];
`endif
        pt_valid_next  = 1'b1;
        state_next     = HOLD;
      end
      HOLD: begin
        if (pt_ready) begin
          pt_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      idx_reg       <= '0;
      v_reg         <= '0;
      plaintext_reg <= '0;
      pt_valid_reg  <= 1'b0;
`ifdef DECRYPT_NOISE_OUT_EN
      noise_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      idx_reg       <= idx_next;
      v_reg         <= v_next;
      plaintext_reg <= plaintext_next;
      pt_valid_reg  <= pt_valid_next;
`ifdef DECRYPT_NOISE_OUT_EN
      noise_reg     <= noise_next;
`endif
    end
  end

  assign ct_ready  = (state_reg == ACCUM);
  assign plaintext = plaintext_reg;
  assign pt_valid  = pt_valid_reg;

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: directed cases plus random ciphertexts
// against an arithmetic reference model, on DIMENSION=1 and DIMENSION=4 instances.
module tb_decrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go1 = 1'b0, go4 = 1'b0;
  logic [9:0] ct_data = '0;
  logic       ct_valid = 1'b0;
  logic       pt_ready = 1'b0;
  logic [9:0] key1 [0:0];
  logic [9:0] key4 [3:0];
  logic       ct_ready1, pt_valid1, ct_ready4, pt_valid4;
  logic [5:0] plaintext1, plaintext4;
`ifdef DECRYPT_NOISE_OUT_EN
  logic signed [4:0] noise1, noise4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ks [4];

  always #5 clk = ~clk;

  decrypt dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .secretkey(key1),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready1),
    .plaintext(plaintext1), .pt_valid(pt_valid1),
`ifdef DECRYPT_NOISE_OUT_EN
    .noise(noise1),
`endif
    .pt_ready(pt_ready)
  );

  decrypt #(.DIMENSION(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .go(go4), .secretkey(key4),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready4),
    .plaintext(plaintext4), .pt_valid(pt_valid4),
`ifdef DECRYPT_NOISE_OUT_EN
    .noise(noise4),
`endif
    .pt_ready(pt_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get(input int dim, output logic [31:0] rdy, output logic [31:0] vld,
                     output logic [31:0] pt, output logic [31:0] nz);
    nz = '0;
    if (dim == 1) begin
      rdy = 32'(ct_ready1); vld = 32'(pt_valid1); pt = 32'(plaintext1);
`ifdef DECRYPT_NOISE_OUT_EN
      nz = 32'($signed(noise1));
`endif
    end else begin
      rdy = 32'(ct_ready4); vld = 32'(pt_valid4); pt = 32'(plaintext4);
`ifdef DECRYPT_NOISE_OUT_EN
      nz = 32'($signed(noise4));
`endif
    end
  endtask

  // Reference: exact rational rounding of v*p/q, noise as the centred residue mod q.
  task automatic model(input int dim, input int a [4], input int b, output int pt, output int e);
    int acc, v;
    acc = 0;
    for (int i = 0; i < dim; i++) acc += a[i] * ks[i];
    v  = ((b - acc) % 1024 + 1024) % 1024;
    pt = ((v * 64 + 512) / 1024) % 64;
    e  = (((v - pt * 16) % 1024) + 1024) % 1024;
    if (e >= 512) e -= 1024;
  endtask

  task automatic load_keys();
    key1[0] = 10'(ks[0]);
    for (int i = 0; i < 4; i++) key4[i] = 10'(ks[i]);
  endtask

  task automatic pulse_go(input int dim);
    if (dim == 1) go1 = 1'b1; else go4 = 1'b1;
    step();
    go1 = 1'b0;
    go4 = 1'b0;
  endtask

  task automatic run(input int dim, input int a [4], input int b, input int gap,
                     input int hold, input string tag);
    int exp_pt, exp_e;
    logic [31:0] rdy, vld, pt, nz, pt_first;
    model(dim, a, b, exp_pt, exp_e);
    load_keys();
    pulse_go(dim);
    for (int i = 0; i <= dim; i++) begin
      if (i == dim && gap > 0) begin
        ct_valid = 1'b0;
        repeat (gap) step();
        get(dim, rdy, vld, pt, nz);
        chk({tag, "_stall_ready"}, rdy, 1);
        chk({tag, "_stall_valid"}, vld, 0);
      end
      get(dim, rdy, vld, pt, nz);
      chk({tag, "_ct_ready"}, rdy, 1);
      ct_valid = 1'b1;
      ct_data  = (i < dim) ? 10'(a[i]) : 10'(b);
      step();
      ct_valid = 1'b0;
    end
    get(dim, rdy, vld, pt, nz);
    chk({tag, "_valid_early"}, vld, 0);
    step();
    get(dim, rdy, vld, pt, nz);
    chk({tag, "_valid"}, vld, 1);
    chk({tag, "_plaintext"}, pt, 32'(exp_pt));
    chk({tag, "_ready_in_hold"}, rdy, 0);
`ifdef DECRYPT_NOISE_OUT_EN
    chk({tag, "_noise"}, nz, 32'(exp_e));
`endif
    pt_first = pt;
    for (int h = 0; h < hold; h++) begin
      if (dim == 1) go1 = 1'b1; else go4 = 1'b1;
      step();
      get(dim, rdy, vld, pt, nz);
      chk({tag, "_hold_valid"}, vld, 1);
      chk({tag, "_hold_stable"}, pt, pt_first);
      chk({tag, "_hold_ready"}, rdy, 0);
    end
    go1 = 1'b0;
    go4 = 1'b0;
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    get(dim, rdy, vld, pt, nz);
    chk({tag, "_released"}, vld, 0);
    chk({tag, "_idle_ready"}, rdy, 0);
    $display("txn %s dim=%0d b=%0d plaintext=%0d expected=%0d", tag, dim, b, pt_first, exp_pt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdy, vld, pt, nz;
    int ra [4];
    ks = '{0, 0, 0, 0};
    load_keys();
    #2;
    get(1, rdy, vld, pt, nz);
    chk("reset_ct_ready", rdy, 0);
    chk("reset_pt_valid", vld, 0);
    chk("reset_plaintext", pt, 0);
    step();
    rst_n = 1'b1;
    step();

    // pt_ready while idle must not produce anything
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    get(1, rdy, vld, pt, nz);
    chk("idle_pt_ready_valid", vld, 0);

    ks = '{3, 0, 0, 0};
    run(1, '{5, 0, 0, 0}, 177, 0, 0, "nominal");
    run(1, '{1000, 0, 0, 0}, 949, 0, 0, "wrap");
    ks = '{0, 0, 0, 0};
    run(1, '{0, 0, 0, 0}, 1015, 0, 0, "round_63");
    run(1, '{0, 0, 0, 0}, 1016, 0, 0, "round_wrap");
    ks = '{3, 0, 0, 0};
    run(1, '{5, 0, 0, 0}, 177, 3, 5, "backpressure");

    // Abort mid-ACCUM: outputs must clear without a clock edge
    ks = '{7, 0, 0, 0};
    load_keys();
    pulse_go(1);
    ct_valid = 1'b1;
    ct_data  = 10'd123;
    step();
    ct_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    get(1, rdy, vld, pt, nz);
    chk("abort_ct_ready", rdy, 0);
    chk("abort_pt_valid", vld, 0);
    chk("abort_plaintext", pt, 0);
    #1 rst_n = 1'b1;
    step();
    run(1, '{200, 0, 0, 0}, 600, 0, 0, "after_abort");

    ks = '{1, 2, 3, 4};
    run(4, '{10, 20, 30, 40}, 897, 0, 0, "dim4");
    run(4, '{10, 20, 30, 40}, 897, 2, 2, "dim4_stall");

    for (int t = 0; t < 24; t++) begin
      int dim;
      dim = (t % 2 == 0) ? 1 : 4;
      for (int i = 0; i < 4; i++) begin
        ks[i] = int'($urandom_range(0, 1023));
        ra[i] = int'($urandom_range(0, 1023));
      end
      run(dim, ra, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 2)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
